puf_bit_serializer: RTL and testbench
=====================================

Name: puf_bit_serializer

Overview:
- Upstream feeder for the NIST-style randomness test stages (frequency, overlapping template, etc.).
- Buffers PUF response words arriving with a valid/ready handshake in a small FIFO. Serializes them LSB-first into the continuous one-bit-per-clock `rand` stream those tests consume.
- Holds the downstream tests in reset until the FIFO is prefilled.
- Forces a test restart on underrun, because a gap in the bit stream invalidates the running statistic.

Parameters:
- W, 32, PUF response word width in bits (≥2).
- DEPTH, 16, FIFO depth in words; power of 2, ≥2.
- PREFILL, 8, FIFO occupancy required before streaming starts; 1..DEPTH.
- AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- word_in  input  W  PUF response word.
- word_valid  input  1  word_in valid.
- word_ready  output  1  FIFO can accept a word; equals !full.
- clear_err  input  1  synchronous clear of the sticky underrun flag.
- rand  output  1  serialized bit to the test stages; registered.
- test_rst  output  1  synchronous reset for the downstream test stages; registered.
- running  output  1  high while in RUN.
- underrun  output  1  sticky; set when a word is needed and the FIFO is empty.
- occupancy  output  AW+1  current FIFO word count.

Behaviour:
- Reset: all outputs take their reset values asynchronously while rst is high.
  - FIFO empty, occupancy=0, word_ready=1.
  - rand=0, test_rst=1, running=0, underrun=0, state=FILL, bit_idx=0.
- Push: a word is written on a clk edge with word_valid && word_ready.
  - When full, word_ready=0, even if a pop happens the same cycle (no pass-through).
- States: FILL, RUN, FAULT.
- FILL:
  - test_rst=1, running=0, rand=0.
  - When occupancy ≥ PREFILL at a clk edge, the next cycle is RUN.
  - On that edge: pop the head word into the shift register, drive rand=word[0], set test_rst=0 and running=1, set bit_idx=1.
- RUN:
  - Every edge drives rand=shreg[bit_idx], then bit_idx increments.
  - When bit_idx==W-1, the next edge pops a new word and drives its bit 0 (bit_idx←1). The stream has no bubble between words.
  - Each word contributes exactly W consecutive bits, LSB first.
- Underrun:
  - Occurs in RUN when a pop is due and occupancy==0 at that edge.
  - A push arriving the same edge does not rescue it; there is no bypass.
  - Response on that edge: next state FAULT, underrun←1, test_rst←1, running←0, rand←0.
- FAULT:
  - Lasts exactly one cycle, then goes to FILL.
  - The FIFO is not flushed; the words already held count toward the prefill.
- clear_err:
  - Clears underrun on the next edge.
  - If an underrun occurs in the same cycle, the set wins.
- Occupancy:
  - Push only: +1. Pop only: −1. Push and pop together: unchanged.
  - Pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH.
- Reset mid-stream: asynchronous return to the reset values. FIFO contents are discarded because the pointers are reset.

Decomposition:
- Shared package `puf_test_pkg`:
  - localparam `PUF_WORD_W=32`.
  - State enum {FILL, RUN, FAULT}.
  - NIST block constants (block length 1032, block count 1000), shared with the test stages.
- One sub-module: `sync_word_fifo`, a parameterized W×DEPTH FIFO.
  - Ports: push, pop, full, empty, count.
  - Async active-high reset.

Test Plan:
- Reset release with word_valid=0 → word_ready=1, test_rst=1, running=0, occupancy=0, underrun=0 for 20 cycles.
- Push 8 words 0x00000001..0x00000008 (PREFILL=8) →
  - running and test_rst=0 the edge after occupancy reaches 8.
  - First 32 rand bits are 1,0,…,0; the next 32 bits are 0,1,0,…,0 with no gap at the boundary.
- Push 16 words without pops (PREFILL=16) → word_ready=0 at occupancy=16. A 17th word held valid is not accepted, and the word sequence is intact after streaming starts.
- Prefill 8 words, then stop pushing → after 256 bits:
  - underrun=1, test_rst=1 for FAULT and then FILL, running=0.
  - underrun stays 1 until clear_err is pulsed, then reads 0 on the next edge.
- Underrun edge with word_valid=1 on the same edge → underrun still set. The word is stored (occupancy=1) and streaming restarts only after occupancy reaches 8.
- Assert rst asynchronously mid-word (bit_idx=13, occupancy=5) → outputs return to their reset values immediately without waiting for a clk edge. After release, occupancy=0 and state=FILL.

Source files
------------

// File: rtl/puf_test_pkg.sv
// Shared definitions for the PUF randomness-test datapath.
//   PUF_WORD_W      : default PUF response word width
//   ser_state_t     : serializer control states (FILL, RUN, FAULT)
//   NIST_BLOCK_LEN  : bits per block for the blocked NIST statistics
//   NIST_BLOCK_CNT  : blocks per test run
package puf_test_pkg;

    localparam int PUF_WORD_W      = 32;
    localparam int NIST_BLOCK_LEN  = 1032;
    localparam int NIST_BLOCK_CNT  = 1000;
    localparam int NIST_STREAM_LEN = NIST_BLOCK_LEN * NIST_BLOCK_CNT;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } ser_state_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock W x DEPTH word FIFO with an occupancy count.
//   clk, rst : clock, async active-high reset (pointers and count only)
//   din/push : write data and write request (ignored while full)
//   dout/pop : head word (combinational) and read request (ignored while empty)
//   full, empty, count : status; count ranges 0..DEPTH
module sync_word_fifo
    import puf_test_pkg::*;
#(
    parameter int W     = PUF_WORD_W,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         push,
    output logic [W-1:0] dout,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Full blocks a push even when a pop lands on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/puf_bit_serializer.sv
// Buffers PUF response words and serializes them LSB-first into a gap-free
// one-bit-per-clock stream for the downstream randomness tests.
//   clk, rst           : clock, async active-high reset
//   word_in/word_valid : upstream word and its valid
//   word_ready         : FIFO not full
//   clear_err          : clears the sticky underrun flag
//   rand_bit           : serialized random bit (registered)
//   test_rst           : holds the test stages in reset (registered)
//   running            : streaming is live
//   underrun           : sticky, a word was due but the FIFO was empty
//   occupancy          : FIFO word count
module puf_bit_serializer
    import puf_test_pkg::*;
#(
    parameter int W       = PUF_WORD_W,
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] word_in,
    input  logic         word_valid,
    output logic         word_ready,
    input  logic         clear_err,
    output logic         rand_bit,
    output logic         test_rst,
    output logic         running,
    output logic         underrun,
    output logic [AW:0]  occupancy
);

    localparam int BW = $clog2(W);

    ser_state_t    state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic          rand_d, test_rst_d, running_d, underrun_d;
    logic          pop, set_err;
    logic [W-1:0]  head;
    logic          full, empty;

    sync_word_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .din   (word_in),
        .push  (word_valid),
        .dout  (head),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    assign word_ready = !full;

    // bit_idx==0 while in RUN means the current word is exhausted and the
    // next edge must load a fresh one; bit 0 of a new word is taken straight
    // from the FIFO head so there is no bubble between words.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        rand_d     = 1'b0;
        test_rst_d = 1'b1;
        running_d  = 1'b0;
        pop        = 1'b0;
        set_err    = 1'b0;
        case (state_q)
            FILL: begin
                if (occupancy >= (AW+1)'(PREFILL)) begin
                    pop        = 1'b1;
                    shreg_d    = head;
                    rand_d     = head[0];
                    test_rst_d = 1'b0;
                    running_d  = 1'b1;
                    bit_idx_d  = BW'(1);
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (bit_idx_q == '0) begin
                    if (empty) begin
                        // No bypass: a push on this edge cannot fill the gap.
                        set_err   = 1'b1;
                        bit_idx_d = '0;
                        state_d   = FAULT;
                    end else begin
                        pop        = 1'b1;
                        shreg_d    = head;
                        rand_d     = head[0];
                        test_rst_d = 1'b0;
                        running_d  = 1'b1;
                        bit_idx_d  = BW'(1);
                    end
                end else begin
                    rand_d     = shreg_q[bit_idx_q];
                    test_rst_d = 1'b0;
                    running_d  = 1'b1;
                    bit_idx_d  = (bit_idx_q == BW'(W-1)) ? '0 : bit_idx_q + 1'b1;
                end
            end
            FAULT: begin
                // One-cycle hold; the FIFO keeps its words toward the prefill.
                bit_idx_d = '0;
                state_d   = FILL;
            end
            default: begin
                bit_idx_d = '0;
                state_d   = FILL;
            end
        endcase
        // Set beats clear when both land on the same edge.
        underrun_d = set_err | (underrun && !clear_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            rand_bit  <= 1'b0;
            test_rst  <= 1'b1;
            running   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            rand_bit  <= rand_d;
            test_rst  <= test_rst_d;
            running   <= running_d;
            underrun  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_puf_bit_serializer.sv
// Directed bench: one instance with PREFILL=8 (streaming, underrun, reset)
// and one with PREFILL=16 (full FIFO / backpressure).
module tb_puf_bit_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_err = 1'b0;

    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready, rand1, test_rst1, running1, underrun1;
    logic [4:0]  occ1;

    logic [31:0] word_in2 = '0;
    logic        word_valid2 = 1'b0;
    logic        word_ready2, rand2, test_rst2, running2, underrun2;
    logic [4:0]  occ2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    puf_bit_serializer #(.W(32), .DEPTH(16), .PREFILL(8)) u_dut (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .clear_err(clear_err), .rand_bit(rand1),
        .test_rst(test_rst1), .running(running1), .underrun(underrun1),
        .occupancy(occ1)
    );

    puf_bit_serializer #(.W(32), .DEPTH(16), .PREFILL(16)) u_full (
        .clk(clk), .rst(rst), .word_in(word_in2), .word_valid(word_valid2),
        .word_ready(word_ready2), .clear_err(clear_err), .rand_bit(rand2),
        .test_rst(test_rst2), .running(running2), .underrun(underrun2),
        .occupancy(occ2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Collects the next 32 stream bits (tick then sample) and checks the
    // stream stayed live for the whole word.
    task automatic check_word(input string tag, input bit sel, input logic [31:0] exp);
        logic [31:0] w;
        bit ok;
        w  = '0;
        ok = 1'b1;
        for (int b = 0; b < 32; b++) begin
            tick();
            w[b] = sel ? rand2 : rand1;
            if (sel ? (!running2 || test_rst2) : (!running1 || test_rst1)) ok = 1'b0;
        end
        chk(tag, w, exp);
        chk({tag, "_live"}, 32'(ok), 1);
    endtask

    initial begin
        logic [31:0] w;

        // Reset values while rst is held.
        tick();
        tick();
        chk("rst_ready",    32'(word_ready), 1);
        chk("rst_test_rst", 32'(test_rst1),  1);
        chk("rst_running",  32'(running1),   0);
        chk("rst_occ",      32'(occ1),       0);
        chk("rst_underrun", 32'(underrun1),  0);
        chk("rst_rand",     32'(rand1),      0);
        rst = 1'b0;

        // Idle after release, no words offered.
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_ready",    32'(word_ready), 1);
            chk("idle_test_rst", 32'(test_rst1),  1);
            chk("idle_running",  32'(running1),   0);
            chk("idle_occ",      32'(occ1),       0);
            chk("idle_underrun", 32'(underrun1),  0);
        end

        // Full FIFO: PREFILL=16 instance.
        for (int i = 0; i < 16; i++) begin
            chk("full_ready_pre", 32'(word_ready2), 1);
            word_in2    = 32'h100 + i;
            word_valid2 = 1'b1;
            tick();
        end
        chk("full_occ16",   32'(occ2),        16);
        chk("full_ready0",  32'(word_ready2), 0);
        chk("full_not_run", 32'(running2),    0);
        word_in2 = 32'hDEADBEEF;
        tick();
        chk("full_no_accept", 32'(occ2),      15);
        chk("full_running",   32'(running2),  1);
        chk("full_test_rst",  32'(test_rst2), 0);
        w    = '0;
        w[0] = rand2;
        word_valid2 = 1'b0;
        for (int b = 1; b < 32; b++) begin
            tick();
            w[b] = rand2;
        end
        chk("full_word0", w, 32'h100);
        for (int i = 1; i < 16; i++) check_word("full_word", 1'b1, 32'h100 + i);
        tick();
        chk("full_underrun", 32'(underrun2), 1);
        chk("full_stopped",  32'(running2),  0);

        // Prefill 8 words then starve.
        for (int i = 1; i <= 8; i++) begin
            word_in    = i;
            word_valid = 1'b1;
            tick();
        end
        word_valid = 1'b0;
        chk("pf_occ8",     32'(occ1),      8);
        chk("pf_not_run",  32'(running1),  0);
        chk("pf_test_rst", 32'(test_rst1), 1);
        check_word("stream_w1", 1'b0, 32'h1);
        chk("stream_occ7", 32'(occ1), 7);
        for (int i = 2; i <= 8; i++) check_word("stream_w", 1'b0, i);
        chk("stream_occ0", 32'(occ1),     0);
        chk("stream_run",  32'(running1), 1);
        tick();
        chk("ur_flag",     32'(underrun1), 1);
        chk("ur_test_rst", 32'(test_rst1), 1);
        chk("ur_running",  32'(running1),  0);
        chk("ur_rand",     32'(rand1),     0);
        tick();
        chk("fill_test_rst", 32'(test_rst1), 1);
        chk("fill_running",  32'(running1),  0);
        chk("fill_underrun", 32'(underrun1), 1);
        repeat (5) tick();
        chk("ur_sticky", 32'(underrun1), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("ur_cleared", 32'(underrun1), 0);

        // Underrun with a push and a clear on the same edge.
        for (int i = 0; i < 8; i++) begin
            word_in    = 32'h11 + i;
            word_valid = 1'b1;
            tick();
        end
        word_valid = 1'b0;
        for (int i = 0; i < 8; i++) check_word("s2_w", 1'b0, 32'h11 + i);
        word_in    = 32'hA5;
        word_valid = 1'b1;
        clear_err  = 1'b1;
        tick();
        word_valid = 1'b0;
        clear_err  = 1'b0;
        chk("ur2_set_wins", 32'(underrun1), 1);
        chk("ur2_occ1",     32'(occ1),      1);
        chk("ur2_running",  32'(running1),  0);
        chk("ur2_test_rst", 32'(test_rst1), 1);
        tick();
        chk("ur2_fill_run", 32'(running1), 0);
        chk("ur2_fill_occ", 32'(occ1),     1);
        for (int k = 0; k < 7; k++) begin
            word_in    = 32'hB1 + k;
            word_valid = 1'b1;
            tick();
        end
        word_valid = 1'b0;
        chk("ur2_occ8",    32'(occ1),     8);
        chk("ur2_not_run", 32'(running1), 0);
        check_word("restart_w0", 1'b0, 32'hA5);
        check_word("restart_w1", 1'b0, 32'hB1);
        repeat (13) tick();
        chk("mid_occ5",    32'(occ1),     5);
        chk("mid_running", 32'(running1), 1);

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b1;
        #1;
        chk("async_running",  32'(running1),   0);
        chk("async_test_rst", 32'(test_rst1),  1);
        chk("async_occ",      32'(occ1),       0);
        chk("async_ready",    32'(word_ready), 1);
        chk("async_rand",     32'(rand1),      0);
        chk("async_underrun", 32'(underrun1),  0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_occ",      32'(occ1),      0);
        chk("post_running",  32'(running1),  0);
        chk("post_test_rst", 32'(test_rst1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
